// File: rtl/blake_stream_if_if.sv
`default_nettype none
// ============================================================================
// Module  : blake_stream_if_if
// Purpose : valid/ready message-in and digest-out streams of the BLAKE host port
// Revision: 1.0
// ============================================================================
interface blake_stream_if_if #(
    parameter int BUS_W = 16
);
    logic [BUS_W-1:0] idata;
    logic             ivalid;
    logic             iready;
    logic [BUS_W-1:0] odata;
    logic             ovalid;
    logic             oready;

    modport master (
        output idata, ivalid, oready,
        input  iready, odata, ovalid
    );

    modport slave (
        input  idata, ivalid, oready,
        output iready, odata, ovalid
    );
endinterface
`default_nettype wire

// File: rtl/blake_stream_if.sv
`default_nettype none
// ============================================================================
// Module  : blake_stream_if
// Purpose : host stream to BLAKE core: length/block intake, counter, digest out
// Revision: 1.0
// ============================================================================
module blake_stream_if #(
    parameter int BUS_W        = 16,
    parameter int WORD_W       = 32,
    parameter int DIGEST_WORDS = 8,
    parameter int CNT_W        = 64
) (
    input  wire logic                           clk,
    input  wire logic                           rst_n,
    input  wire logic                           init,
    input  wire logic                           fetch,
    blake_stream_if_if.slave                    strm,
    output logic     [WORD_W-1:0]               word_out,
    output logic     [3:0]                      word_idx,
    output logic                                word_we,
    output logic                                start,
    output logic                                last_block,
    input  wire logic                           busy,
    input  wire logic [DIGEST_WORDS*WORD_W-1:0] digest,
    output logic     [CNT_W-1:0]                counter
);
    localparam int BPW        = WORD_W / BUS_W;
    localparam int LEN_BEATS  = CNT_W / BUS_W;
    localparam int BLK_BEATS  = 16 * BPW;
    localparam int BLOCK_BITS = 16 * WORD_W;
    localparam int OUT_BEATS  = DIGEST_WORDS * BPW;
    localparam int DIG_W      = DIGEST_WORDS * WORD_W;
    localparam int BC_W       = $clog2(BLK_BEATS);
    localparam int OC_W       = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam int BPW_LOG    = $clog2(BPW);

    localparam logic [BC_W-1:0] C_WORD_MASK = BC_W'(BPW - 1);
    localparam logic [BC_W-1:0] C_LEN_LAST  = BC_W'(LEN_BEATS - 1);
    localparam logic [BC_W-1:0] C_BLK_LAST  = BC_W'(BLK_BEATS - 1);
    localparam logic [OC_W-1:0] C_OUT_LAST  = OC_W'(OUT_BEATS - 1);
    localparam logic [CNT_W:0]  C_BLK_BITS  = (CNT_W+1)'(BLOCK_BITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_BLK   = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [BC_W-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]   length_q, length_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [WORD_W-1:0]  word_sh_q, word_sh_d;
    logic [WORD_W-1:0]  word_out_q, word_out_d;
    logic [3:0]         word_idx_q, word_idx_d;
    logic               word_we_q, word_we_d;
    logic               start_q, start_d;
    logic               last_q, last_d;
    logic               iready_q, iready_d;
    logic               ovalid_q, ovalid_d;
    logic [DIG_W-1:0]   dig_q, dig_d;
    logic [OC_W-1:0]    ocnt_q, ocnt_d;
    logic               wait_first_q, wait_first_d;

    logic               in_fire;
    logic               out_fire;
    logic [WORD_W-1:0]  word_nxt;
    logic [CNT_W:0]     cnt_sum;
    logic [CNT_W-1:0]   cnt_new;
    logic               last_new;

    always_comb begin
        in_fire  = strm.ivalid & iready_q;
        out_fire = ovalid_q & strm.oready;
        word_nxt = (word_sh_q << BUS_W) | WORD_W'(strm.idata);

        // A block issued when counter already equals length is the trailing
        // padding-only block, which the core must see with a zero counter.
        cnt_sum = {1'b0, counter_q} + C_BLK_BITS;
        if (counter_q == length_q) begin
            cnt_new = '0;
        end else if (cnt_sum > {1'b0, length_q}) begin
            cnt_new = length_q;
        end else begin
            cnt_new = cnt_sum[CNT_W-1:0];
        end
        last_new = (cnt_new >= length_q) | (counter_q == length_q);
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        length_d     = length_q;
        counter_d    = counter_q;
        word_sh_d    = word_sh_q;
        word_out_d   = word_out_q;
        word_idx_d   = word_idx_q;
        word_we_d    = 1'b0;
        start_d      = 1'b0;
        last_d       = last_q;
        dig_d        = dig_q;
        ocnt_d       = ocnt_q;
        wait_first_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fetch) begin
                    state_d = S_OUT;
                    dig_d   = digest;
                    ocnt_d  = '0;
                end
            end
            S_LEN: begin
                if (in_fire) begin
                    length_d = (length_q << BUS_W) | CNT_W'(strm.idata);
                    if (beat_q == C_LEN_LAST) begin
                        beat_d  = '0;
                        state_d = S_BLK;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_BLK: begin
                if (in_fire) begin
                    word_sh_d = word_nxt;
                    if ((beat_q & C_WORD_MASK) == C_WORD_MASK) begin
                        word_out_d = word_nxt;
                        word_idx_d = 4'(beat_q >> BPW_LOG);
                        word_we_d  = 1'b1;
                    end
                    if (beat_q == C_BLK_LAST) begin
                        beat_d  = '0;
                        state_d = S_ISSUE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (fetch && (beat_q == '0)) begin
                    state_d = S_OUT;
                    dig_d   = digest;
                    ocnt_d  = '0;
                end
            end
            S_ISSUE: begin
                start_d      = 1'b1;
                counter_d    = cnt_new;
                last_d       = last_new;
                wait_first_d = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                // busy lags start by one cycle, so the first WAIT cycle is blind
                if (!wait_first_q && !busy) begin
                    state_d = S_BLK;
                end
            end
            S_OUT: begin
                if (out_fire) begin
                    dig_d = dig_q << BUS_W;
                    if (ocnt_q == C_OUT_LAST) begin
                        ocnt_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        ocnt_d = ocnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (init) begin
            state_d      = S_LEN;
            beat_d       = '0;
            length_d     = '0;
            counter_d    = '0;
            word_sh_d    = '0;
            word_we_d    = 1'b0;
            start_d      = 1'b0;
            last_d       = 1'b0;
            ocnt_d       = '0;
            wait_first_d = 1'b0;
        end

        iready_d = (state_d == S_LEN) || (state_d == S_BLK);
        ovalid_d = (state_d == S_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            length_q     <= '0;
            counter_q    <= '0;
            word_sh_q    <= '0;
            word_out_q   <= '0;
            word_idx_q   <= '0;
            word_we_q    <= 1'b0;
            start_q      <= 1'b0;
            last_q       <= 1'b0;
            iready_q     <= 1'b0;
            ovalid_q     <= 1'b0;
            dig_q        <= '0;
            ocnt_q       <= '0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            length_q     <= length_d;
            counter_q    <= counter_d;
            word_sh_q    <= word_sh_d;
            word_out_q   <= word_out_d;
            word_idx_q   <= word_idx_d;
            word_we_q    <= word_we_d;
            start_q      <= start_d;
            last_q       <= last_d;
            iready_q     <= iready_d;
            ovalid_q     <= ovalid_d;
            dig_q        <= dig_d;
            ocnt_q       <= ocnt_d;
            wait_first_q <= wait_first_d;
        end
    end

    assign strm.iready = iready_q;
    assign strm.ovalid = ovalid_q;
    assign strm.odata  = dig_q[DIG_W-1 -: BUS_W];
    assign word_out    = word_out_q;
    assign word_idx    = word_idx_q;
    assign word_we     = word_we_q;
    assign start       = start_q;
    assign last_block  = last_q;
    assign counter     = counter_q;

endmodule
`default_nettype wire

// File: tb/tb_blake_stream_if.sv
`default_nettype none
// ============================================================================
// Module  : tb_blake_stream_if
// Purpose : directed self-checking bench for blake_stream_if (BLAKE-256 setup)
// Revision: 1.0
// ============================================================================
module tb_blake_stream_if;
    localparam int BUS_W  = 16;
    localparam int WORD_W = 32;
    localparam int DW     = 8;
    localparam int CNT_W  = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init = 1'b0;
    logic              fetch = 1'b0;
    logic              busy_force = 1'b0;
    logic              busy_gen = 1'b0;
    logic              busy;
    logic [DW*WORD_W-1:0] digest = '0;
    logic [WORD_W-1:0] word_out;
    logic [3:0]        word_idx;
    logic              word_we;
    logic              start;
    logic              last_block;
    logic [CNT_W-1:0]  counter;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_len = 0;
    int last_acc = 0;

    blake_stream_if_if #(.BUS_W(BUS_W)) bus ();

    assign busy = busy_force | busy_gen;

    blake_stream_if #(
        .BUS_W(BUS_W), .WORD_W(WORD_W), .DIGEST_WORDS(DW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .fetch(fetch), .strm(bus),
        .word_out(word_out), .word_idx(word_idx), .word_we(word_we),
        .start(start), .last_block(last_block), .busy(busy),
        .digest(digest), .counter(counter)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled mid-cycle
    logic [3:0]        we_idx [256];
    logic [31:0]       we_word[256];
    int                we_cyc [256];
    logic [63:0]       st_ctr [64];
    logic              st_last[64];
    int                st_cyc [64];
    logic [15:0]       ob     [64];
    int we_n = 0, st_n = 0, ob_n = 0, ov_n = 0, busy_viol = 0;

    always @(negedge clk) begin
        if (word_we && we_n < 256) begin
            we_idx[we_n] = word_idx; we_word[we_n] = word_out; we_cyc[we_n] = cyc; we_n++;
        end
        if (start && st_n < 64) begin
            st_ctr[st_n] = counter; st_last[st_n] = last_block; st_cyc[st_n] = cyc; st_n++;
        end
        if (bus.ovalid) ov_n++;
        if (bus.ovalid && bus.oready && ob_n < 64) begin
            ob[ob_n] = bus.odata; ob_n++;
        end
        if (busy && bus.iready) busy_viol++;
    end

    // Core model: raises busy the cycle after start for busy_len cycles
    initial begin
        forever begin
            @(posedge clk); #1;
            if (start && busy_len > 0) begin
                @(posedge clk); #1;
                busy_gen = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1;
                busy_gen = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [15:0] data);
        logic ok;
        int   n;
        ok = 1'b0; n = 0;
        bus.idata = data; bus.ivalid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.iready;
            if (ok) last_acc = cyc;
            @(posedge clk); #1;
            n++;
        end
        bus.ivalid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: beat %h not accepted, iready=%b required 1", data, bus.iready);
        end
    endtask

    task automatic send_header(input logic [63:0] len);
        for (int i = 0; i < 4; i++) send(len[63-16*i -: 16]);
    endtask

    task automatic send_block(input logic [15:0] base);
        for (int i = 0; i < 32; i++) send(base + 16'(i));
    endtask

    task automatic pulse_init();
        init = 1'b1; tick(); init = 1'b0;
    endtask

    task automatic check_block_words(input int we0, input logic [15:0] base, input string tag);
        logic [31:0] exp;
        checks++;
        if (we_n - we0 !== 16) begin
            errors++; $display("FAIL %s_we_count: got %0d required 16", tag, we_n - we0);
        end else begin
            for (int i = 0; i < 16; i++) begin
                exp = {base + 16'(2*i), base + 16'(2*i+1)};
                checks++;
                if (we_idx[we0+i] !== 4'(i) || we_word[we0+i] !== exp) begin
                    errors++;
                    $display("FAIL %s_word%0d: got idx %0d word %h required idx %0d word %h",
                             tag, i, we_idx[we0+i], we_word[we0+i], i, exp);
                end
            end
        end
    endtask

    task automatic check_start(input int k, input logic [63:0] ctr, input logic last, input string tag);
        checks++;
        if (st_n <= k) begin
            errors++; $display("FAIL %s_start_missing: got %0d starts required > %0d", tag, st_n, k);
        end else if (st_ctr[k] !== ctr || st_last[k] !== last) begin
            errors++;
            $display("FAIL %s: got counter %h last %b required counter %h last %b",
                     tag, st_ctr[k], st_last[k], ctr, last);
        end
    endtask

    task automatic test_reset();
        init = 1'b1; fetch = 1'b1; busy_force = 1'b1;
        bus.ivalid = 1'b1; bus.idata = 16'hFFFF; bus.oready = 1'b1;
        digest = {8{32'hA5A5_5A5A}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.iready, bus.ovalid, bus.odata, word_we, word_idx, word_out,
                 start, last_block, counter} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got iready %b ovalid %b odata %h we %b idx %h word %h start %b last %b ctr %h required all 0",
                         bus.iready, bus.ovalid, bus.odata, word_we, word_idx, word_out, start, last_block, counter);
            end
        end
        tick();
        init = 1'b0; fetch = 1'b0; busy_force = 1'b0;
        bus.ivalid = 1'b0; bus.idata = '0; bus.oready = 1'b0;
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (bus.iready !== 1'b0 || bus.ovalid !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got iready %b ovalid %b required 0 0", bus.iready, bus.ovalid);
        end
    endtask

    task automatic test_single_block();
        int we0, st0;
        busy_len = 0;
        pulse_init();
        send_header(64'h200);
        we0 = we_n; st0 = st_n;
        send_block(16'h0000);
        repeat (6) tick();
        check_block_words(we0, 16'h0000, "single");
        checks++;
        if (we_n - we0 == 16 && we_cyc[we0+15] !== last_acc + 1) begin
            errors++; $display("FAIL single_we15_latency: got %0d required %0d", we_cyc[we0+15] - last_acc, 1);
        end
        checks++;
        if (st_n - st0 !== 1) begin
            errors++; $display("FAIL single_start_count: got %0d required 1", st_n - st0);
        end else if (st_cyc[st0] !== last_acc + 2) begin
            errors++; $display("FAIL single_start_latency: got %0d required 2", st_cyc[st0] - last_acc);
        end
        check_start(st0, 64'h200, 1'b1, "single_ctr");
    endtask

    task automatic test_busy_stall();
        int st0, v0;
        busy_len = 5;
        pulse_init();
        send_header(64'h300);
        st0 = st_n; v0 = busy_viol;
        send_block(16'h0100);
        send_block(16'h0200);
        repeat (12) tick();
        check_start(st0,   64'h200, 1'b0, "stall_blk1");
        check_start(st0+1, 64'h300, 1'b1, "stall_blk2");
        checks++;
        if (busy_viol !== v0) begin
            errors++; $display("FAIL stall_iready_busy: got %0d cycles iready high under busy required 0", busy_viol - v0);
        end
    endtask

    task automatic test_three_blocks();
        int st0;
        busy_len = 2;
        pulse_init();
        send_header(64'h400);
        st0 = st_n;
        send_block(16'h1000);
        send_block(16'h2000);
        send_block(16'h3000);
        repeat (10) tick();
        checks++;
        if (st_n - st0 !== 3) begin
            errors++; $display("FAIL three_start_count: got %0d required 3", st_n - st0);
        end
        check_start(st0,   64'h200, 1'b0, "three_blk1");
        check_start(st0+1, 64'h400, 1'b1, "three_blk2");
        check_start(st0+2, 64'h000, 1'b1, "three_blk3");
    endtask

    task automatic test_fetch();
        logic [255:0] dexp;
        int ob0, n;
        dexp = {32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
                32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
        busy_len = 0;
        n = 0;
        while (bus.iready !== 1'b1 && n < 50) begin tick(); n++; end
        digest = dexp;
        bus.oready = 1'b0;
        ob0 = ob_n;
        fetch = 1'b1; tick(); fetch = 1'b0;
        checks++;
        if (bus.ovalid !== 1'b1 || bus.odata !== 16'h6A09) begin
            errors++; $display("FAIL fetch_first: got ovalid %b odata %h required 1 6a09", bus.ovalid, bus.odata);
        end
        for (int k = 0; k < 100 && (ob_n - ob0) < 16; k++) begin
            bus.oready = (k % 2 == 0);
            tick();
            if (k == 5) digest = ~dexp;
        end
        bus.oready = 1'b0;
        repeat (4) tick();
        checks++;
        if (ob_n - ob0 !== 16) begin
            errors++; $display("FAIL fetch_beat_count: got %0d required 16", ob_n - ob0);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (ob[ob0+i] !== dexp[255-16*i -: 16]) begin
                    errors++; $display("FAIL fetch_beat%0d: got %h required %h", i, ob[ob0+i], dexp[255-16*i -: 16]);
                end
            end
        end
        checks++;
        if (bus.ovalid !== 1'b0 || bus.iready !== 1'b0) begin
            errors++; $display("FAIL fetch_idle: got ovalid %b iready %b required 0 0", bus.ovalid, bus.iready);
        end
    endtask

    task automatic test_init_abort();
        int st0, ov0, we0;
        busy_len = 0;
        pulse_init();
        send_header(64'h400);
        send_block(16'h5000);
        for (int i = 0; i < 10; i++) send(16'h7000 + 16'(i));
        st0 = st_n; ov0 = ov_n;
        init = 1'b1; fetch = 1'b1; tick(); init = 1'b0; fetch = 1'b0;
        repeat (40) tick();
        checks++;
        if (st_n !== st0) begin
            errors++; $display("FAIL abort_start: got %0d starts required 0", st_n - st0);
        end
        checks++;
        if (counter !== 64'h0) begin
            errors++; $display("FAIL abort_counter: got %h required 0", counter);
        end
        checks++;
        if (ov_n !== ov0) begin
            errors++; $display("FAIL abort_ovalid: got %0d ovalid cycles required 0", ov_n - ov0);
        end
        checks++;
        if (bus.iready !== 1'b1) begin
            errors++; $display("FAIL abort_iready: got %b required 1", bus.iready);
        end
        send_header(64'h200);
        we0 = we_n; st0 = st_n;
        send_block(16'h0040);
        repeat (6) tick();
        check_block_words(we0, 16'h0040, "abort_next");
        check_start(st0, 64'h200, 1'b1, "abort_next_ctr");
    endtask

    initial begin
        bus.idata = '0; bus.ivalid = 1'b0; bus.oready = 1'b0;
        test_reset();
        test_single_block();
        test_busy_stall();
        test_three_blocks();
        test_fetch();
        test_init_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
